// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency synchronous
// IMEM, and presents instr/pc/valid plus the immediate-format select to decode.
// A one-entry hold register keeps the fetched word stable across decode stalls.
module fetch_stage #(
    parameter int unsigned    N        = 32,
    parameter logic [N-1:0]   RESET_PC = 32'h4000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         redirect,
    input  logic [N-1:0] redirect_pc,
    output logic         imem_en,
    output logic [N-1:0] imem_addr,
    input  logic [N-1:0] imem_rdata,
    output logic [N-1:0] instr,
    output logic [N-1:0] pc,
    output logic         valid,
    output logic [1:0]   imm_sel
);

    localparam int unsigned OPC_W = 7;
    localparam int unsigned SEL_W = 2;

    localparam logic [N-1:0] NOP_INSTR = N'(32'h0000_0013);
    localparam logic [N-1:0] PC_STEP   = N'(4);

    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [SEL_W-1:0] IMM_I = 2'd0;
    localparam logic [SEL_W-1:0] IMM_S = 2'd1;
    localparam logic [SEL_W-1:0] IMM_B = 2'd2;
    localparam logic [SEL_W-1:0] IMM_U = 2'd3;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t       state_q;
    state_t       state_nxt;
    logic [N-1:0] pc_q;
    logic [N-1:0] pc_nxt;
    logic [N-1:0] hold_q;
    logic [N-1:0] hold_nxt;
    logic [N-1:0] pc_inc;
    logic [N-1:0] redirect_addr;

    // Low two bits of the target are forced to zero; keep lint quiet about them.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Sequential and word-aligned redirect addresses (pc+4 wraps modulo 2^N).
    assign pc_inc        = pc_q + PC_STEP;
    assign redirect_addr = {redirect_pc[N-1:2], 2'b00};

    // State, PC and hold registers with asynchronous reset back to BOOT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            hold_q  <= hold_nxt;
        end
    end

    // Next-state and IMEM request: redirect beats stall beats sequential fetch.
    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        hold_nxt  = hold_q;
        imem_en   = 1'b0;
        imem_addr = pc_inc;

        unique case (state_q)
            BOOT: begin
                imem_en   = 1'b1;
                imem_addr = RESET_PC;
                pc_nxt    = RESET_PC;
                state_nxt = RUN;
            end
            RUN, HOLD: begin
                if (redirect) begin
                    // Current instruction is dropped even when decode stalls.
                    imem_en   = 1'b1;
                    imem_addr = redirect_addr;
                    pc_nxt    = redirect_addr;
                    state_nxt = RUN;
                end else if (stall) begin
                    // Capture the returning word only on the first stall cycle.
                    imem_en   = 1'b0;
                    imem_addr = pc_inc;
                    if (state_q == RUN) begin
                        hold_nxt  = imem_rdata;
                        state_nxt = HOLD;
                    end
                end else begin
                    imem_en   = 1'b1;
                    imem_addr = pc_inc;
                    pc_nxt    = pc_inc;
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase

        // No fetch while reset is held.
        if (rst) begin
            imem_en   = 1'b0;
            imem_addr = RESET_PC;
        end
    end

    // Decode-facing instruction and valid selected by the current state.
    always_comb begin
        instr = NOP_INSTR;
        valid = 1'b0;
        unique case (state_q)
            RUN: begin
                instr = imem_rdata;
                valid = 1'b1;
            end
            HOLD: begin
                instr = hold_q;
                valid = 1'b1;
            end
            default: begin
                instr = NOP_INSTR;
                valid = 1'b0;
            end
        endcase
    end

    assign pc = pc_q;

    // Immediate format from the major opcode; J-type is handled downstream.
    always_comb begin
        imm_sel = IMM_I;
        unique case (instr[OPC_W-1:0])
            OPC_STORE:            imm_sel = IMM_S;
            OPC_BRANCH:           imm_sel = IMM_B;
            OPC_LUI, OPC_AUIPC:   imm_sel = IMM_U;
            default:              imm_sel = IMM_I;
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: sync IMEM model, a stream-level reference model of
// what decode should see, a per-cycle compare process and directed checks.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h4000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic [1:0]  imm_sel;

    int tests_run;
    int tests_failed;

    fetch_stage #(.N(32), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .pc         (pc),
        .valid      (valid),
        .imm_sel    (imm_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IMEM contents: preloaded words, otherwise an address hash.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Synchronous IMEM; returns garbage when not enabled.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_rd(imem_addr);
        else         imem_rdata <= $urandom();
    end

    function automatic logic [1:0] ref_imm(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (op == 7'b0100011) return 2'd1;
        if (op == 7'b1100011) return 2'd2;
        if (op == 7'b0110111 || op == 7'b0010111) return 2'd3;
        return 2'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s @%0t: got %08h expected %08h", name, $time, got, exp);
        end
    endtask

    // Reference: whether decode sees a valid word, and which address it came from.
    logic        m_valid;
    logic [31:0] m_pc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 1'b0;
            m_pc    = RESET_PC;
        end else if (!m_valid) begin
            m_valid = 1'b1;
            m_pc    = RESET_PC;
        end else if (redirect) begin
            m_pc = redirect_pc & 32'hFFFF_FFFC;
        end else if (!stall) begin
            m_pc = m_pc + 32'd4;
        end
    end

    // Per-cycle comparison against the reference, away from the active edge.
    bit cmp_on;
    always @(negedge clk) begin
        if (cmp_on) begin
            logic [31:0] e_instr;
            if (rst || !m_valid) begin
                chk("valid", 32'(valid), 32'd0);
                chk("instr", instr, NOP);
                chk("pc", pc, RESET_PC);
                chk("imm_sel", 32'(imm_sel), 32'd0);
                chk("imem_en", 32'(imem_en), rst ? 32'd0 : 32'd1);
                chk("imem_addr", imem_addr, RESET_PC);
            end else begin
                e_instr = mem_rd(m_pc);
                chk("valid", 32'(valid), 32'd1);
                chk("pc", pc, m_pc);
                chk("instr", instr, e_instr);
                chk("imm_sel", 32'(imm_sel), 32'(ref_imm(e_instr)));
                chk("imem_en", 32'(imem_en), (redirect || !stall) ? 32'd1 : 32'd0);
                chk("imem_addr", imem_addr,
                    redirect ? (redirect_pc & 32'hFFFF_FFFC) : (m_pc + 32'd4));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cmp_on       = 1'b0;
        rst          = 1'b1;
        stall        = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = '0;

        mem[32'h4000_0000] = 32'h0000_0093;
        mem[32'h4000_0004] = 32'h0040_0113;
        mem[32'h4000_0008] = 32'h0000_0513;
        mem[32'h4000_000C] = 32'h0000_0593;
        mem[32'h4000_0100] = 32'h0041_2083;
        mem[32'h4000_0104] = 32'h0011_2223;
        mem[32'h4000_0108] = 32'h0020_8463;
        mem[32'h4000_010C] = 32'h1234_50B7;
        mem[32'h4000_0110] = 32'h0000_1097;
        mem[32'h4000_0114] = 32'h0080_00EF;

        #2;
        cmp_on = 1'b1;
        sample();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_en", 32'(imem_en), 32'd0);
        step();
        rst = 1'b0;

        // BOOT cycle
        sample();
        chk("boot_valid", 32'(valid), 32'd0);
        chk("boot_addr", imem_addr, 32'h4000_0000);
        chk("boot_en", 32'(imem_en), 32'd1);
        // Sequential fetch
        step(); sample();
        chk("seq0_pc", pc, 32'h4000_0000);
        chk("seq0_instr", instr, 32'h0000_0093);
        step(); sample();
        chk("seq1_pc", pc, 32'h4000_0004);
        chk("seq1_instr", instr, 32'h0040_0113);
        step();
        stall = 1'b1;
        sample();
        chk("seq2_pc", pc, 32'h4000_0008);
        chk("seq2_instr", instr, 32'h0000_0513);
        chk("stall_en", 32'(imem_en), 32'd0);
        chk("stall_addr", imem_addr, 32'h4000_000C);
        // Two more stalled cycles, held word stable over IMEM garbage
        for (int i = 0; i < 2; i++) begin
            step(); sample();
            chk("hold_instr", instr, 32'h0000_0513);
            chk("hold_pc", pc, 32'h4000_0008);
            chk("hold_imm", 32'(imm_sel), 32'd0);
        end
        // Release cycle presents the held word once more, then pc+4
        step();
        stall = 1'b0;
        sample();
        chk("rel_instr", instr, 32'h0000_0513);
        chk("rel_pc", pc, 32'h4000_0008);
        step(); sample();
        chk("post_pc", pc, 32'h4000_000C);
        chk("post_instr", instr, 32'h0000_0593);

        // Redirect wins over stall, low bits masked
        step();
        redirect    = 1'b1;
        stall       = 1'b1;
        redirect_pc = 32'h4000_0102;
        sample();
        chk("redir_addr", imem_addr, 32'h4000_0100);
        chk("redir_en", 32'(imem_en), 32'd1);
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        sample();
        chk("redir_pc", pc, 32'h4000_0100);
        chk("redir_valid", 32'(valid), 32'd1);
        chk("sweep0", 32'(imm_sel), 32'd0);
        step(); sample(); chk("sweep1", 32'(imm_sel), 32'd1);
        step(); sample(); chk("sweep2", 32'(imm_sel), 32'd2);
        step(); sample(); chk("sweep3", 32'(imm_sel), 32'd3);
        step(); sample(); chk("sweep4", 32'(imm_sel), 32'd3);
        step(); sample(); chk("sweep5", 32'(imm_sel), 32'd0);

        // Wrap at the top of the address space
        step();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        sample();
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        redirect = 1'b0;
        sample();
        chk("wrap_pc0", pc, 32'hFFFF_FFFC);
        step(); sample();
        chk("wrap_pc1", pc, 32'h0000_0000);

        // Async reset while in HOLD
        step();
        stall = 1'b1;
        step();
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_addr", imem_addr, RESET_PC);
        chk("arst_en", 32'(imem_en), 32'd0);
        step();
        rst   = 1'b0;
        stall = 1'b0;
        sample();
        chk("reboot_valid", 32'(valid), 32'd0);
        step(); sample();
        chk("reboot_pc", pc, RESET_PC);
        chk("reboot_instr", instr, 32'h0000_0093);

        // Randomized traffic checked by the compare process
        for (int i = 0; i < 3000; i++) begin
            step();
            stall    = ($urandom_range(0, 99) < 30);
            redirect = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                redirect_pc = $urandom();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 199) == 0) rst = 1'b1;
        end
        step();
        cmp_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RISC-V core. It owns the program counter and drives the synchronous instruction memory (1-cycle read latency). It presents each fetched instruction, its PC and a valid flag to decode, and derives the 2-bit `imm_sel` consumed by the immediate generator. A one-entry hold register keeps the instruction stable while decode stalls, so a stall release costs no bubble.

## Interface

- `N`, 32, datapath and address width.
- `RESET_PC`, 32'h4000_0000, first fetch address after reset (BIOS base).

- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: decode cannot accept `instr` this cycle.
- `redirect` in 1: execute has resolved a taken branch or jump.
- `redirect_pc` in N: target address; bits [1:0] are ignored and treated as 00.
- `imem_en` out 1: IMEM read enable.
- `imem_addr` out N: IMEM read address; data returns on `imem_rdata` at the next edge.
- `imem_rdata` in N: IMEM read data.
- `instr` out N: instruction presented to decode.
- `pc` out N: PC of `instr`.
- `valid` out 1: `instr` and `pc` are meaningful.
- `imm_sel` out 2: immediate format for `instr` (0=I, 1=S, 2=B, 3=U).

## Operation

- Registered state:
  - FSM with states BOOT, RUN and HOLD.
  - `pc`.
  - 32-bit `hold` register.
- `instr`:
  - 32'h0000_0013 (NOP) in BOOT.
  - `hold` in HOLD.
  - `imem_rdata` in RUN.
- `valid`: 0 in BOOT, 1 in RUN and HOLD.
- `imm_sel` is a combinational decode of `instr[6:0]`:
  - 0100011 gives 1.
  - 1100011 gives 2.
  - 0110111 and 0010111 give 3.
  - Every other opcode gives 0. This covers loads, OP-IMM, JALR, JAL, OP and SYSTEM; JAL's J-immediate is built downstream.
- Per-cycle rules. Priority is redirect, then stall, then normal.
  - **BOOT**:
    - Outputs: `imem_en`=1, `imem_addr`=`RESET_PC`.
    - Next edge: `pc`<=`RESET_PC`, go to RUN.
    - `stall` and `redirect` are ignored in BOOT.
  - **redirect** (in RUN or HOLD):
    - Outputs: `imem_en`=1, `imem_addr`={`redirect_pc`[N-1:2],2'b00}.
    - Next edge: `pc`<=that address, go to RUN.
    - The instruction presented this cycle is discarded, even if `stall`=1.
  - **stall, no redirect**:
    - Outputs: `imem_en`=0, `imem_addr`=`pc`+4 (value don't-care for IMEM, but specified).
    - `pc` holds.
    - In RUN: `hold`<=`imem_rdata`, go to HOLD.
    - In HOLD: `hold` is unchanged, stay in HOLD.
  - **normal** (RUN or HOLD, no stall, no redirect):
    - Outputs: `imem_en`=1, `imem_addr`=`pc`+4.
    - Next edge: `pc`<=`pc`+4, go to RUN.
- Arithmetic: `pc`+4 is N-bit modulo. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- A fetched instruction is consumed by decode in any cycle where `valid`=1 and `stall`=0.

## Timing

- Reset (async assert, regardless of clock):
  - State=BOOT, `pc`=`RESET_PC`, `hold`=0.
  - `valid`=0, `instr`=NOP, `imm_sel`=0.
  - While `rst`=1: `imem_en`=0, `imem_addr`=`RESET_PC`.
- After reset deasserts:
  - First edge: address `RESET_PC` is issued and the FSM enters RUN.
  - The following cycle: `valid`=1, `pc`=`RESET_PC`, `instr`=IMEM[`RESET_PC`].
- Fetch latency: 1 cycle from address issue to `instr`. Throughput is 1 instruction per cycle when unstalled.
- Redirect penalty: 1 cycle. The redirect cycle's instruction is dropped; the target is valid on the next cycle.
- Stall release: the held instruction is presented in the release cycle, and `pc`+4 arrives the cycle after. No bubble and no duplicate.
- `rst` asserted mid-stall or mid-redirect: all state is lost and the block returns to BOOT immediately.
- All outputs except `imem_addr`/`imem_en` depend only on registered state and `imem_rdata`. `imem_addr`/`imem_en` additionally depend on `stall` and `redirect`.

## Test plan

- Reset, then run 4 cycles with IMEM[0x4000_0000..0x4000_000C] preloaded:
  - Expect `valid` 0 in the BOOT cycle.
  - Then `pc`=0x4000_0000, 0x4000_0004, 0x4000_0008 on consecutive cycles, with `instr` matching IMEM.
- Stall for 3 cycles while `instr`=0x0000_0513, with IMEM returning garbage while `imem_en`=0:
  - `instr`, `pc` and `imm_sel`=0 stay stable throughout.
  - On release the next cycle shows `pc`+4, with no repeat.
- `redirect`=1 with `redirect_pc`=0x4000_0102 and `stall`=1 in the same cycle:
  - `imem_addr`=0x4000_0100.
  - Next cycle: `pc`=0x4000_0100, `valid`=1, state RUN.
- `imm_sel` sweep:
  - Opcodes 0000011, 0100011, 1100011, 0110111, 0010111 and 1101111 give 0, 1, 2, 3, 3 and 0.
- Wrap: redirect to 0xFFFF_FFFC, then run:
  - The next `pc` is 0x0000_0000.
- Assert `rst` asynchronously during HOLD:
  - `valid` drops to 0 before the next edge, and `imem_addr`=`RESET_PC`.
  - The boot sequence then repeats.
